// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - coin codes, change codes and state encoding for vending_machine_gen2
package vm_pkg;

   localparam logic [2:0] COIN_NONE    = 3'b000;
   localparam logic [2:0] COIN_NICKEL  = 3'b001;
   localparam logic [2:0] COIN_DIME    = 3'b010;
   localparam logic [2:0] COIN_QUARTER = 3'b101;

   localparam logic [2:0] VAL_NICKEL  = 3'd1;
   localparam logic [2:0] VAL_DIME    = 3'd2;
   localparam logic [2:0] VAL_QUARTER = 3'd5;

   localparam logic [1:0] CHG_NONE    = 2'b00;
   localparam logic [1:0] CHG_NICKEL  = 2'b01;
   localparam logic [1:0] CHG_DIME    = 2'b10;
   localparam logic [1:0] CHG_QUARTER = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_VEND    = 2'd2,
      ST_CHANGE  = 2'd3
   } vm_state_t;

   // Value in nickel units; zero marks an invalid (or absent) coin code.
   function automatic logic [2:0] coin_value(input logic [2:0] code);
      logic [2:0] v;
      v = 3'd0;
      case (code)
         COIN_NICKEL:  v = VAL_NICKEL;
         COIN_DIME:    v = VAL_DIME;
         COIN_QUARTER: v = VAL_QUARTER;
         default:      v = 3'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vm_change_sel.sv
// rtl/vm_change_sel.sv - greedy largest-coin-first change selector (combinational)
module vm_change_sel
   import vm_pkg::*;
#(
   parameter int CREDIT_W = 6
) (
   input  logic [CREDIT_W-1:0] credit,
   output logic [1:0]          chg_code,
   output logic [2:0]          chg_value
);

   always_comb begin
      chg_code  = CHG_NICKEL;
      chg_value = VAL_NICKEL;
      if (credit >= CREDIT_W'(VAL_QUARTER)) begin
         chg_code  = CHG_QUARTER;
         chg_value = VAL_QUARTER;
      end else if (credit >= CREDIT_W'(VAL_DIME)) begin
         chg_code  = CHG_DIME;
         chg_value = VAL_DIME;
      end
   end

endmodule

// File: rtl/vending_machine_gen2.sv
// rtl/vending_machine_gen2.sv - parametrised vending FSM with serial change return
// Optional stock counter / sold_out enabled by defining VM_STOCK_EN.
module vending_machine_gen2
   import vm_pkg::*;
#(
   parameter int PRICE_UNITS = 5,
   parameter int CREDIT_W    = 6
`ifdef VM_STOCK_EN
   ,
   parameter logic [7:0] STOCK_INIT = 8'd10
`endif
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic [2:0]          Coin,
   input  logic                Cancel,
   input  logic                chg_ready,
`ifdef VM_STOCK_EN
   input  logic                Restock,
   output logic                sold_out,
`endif
   output logic                vending,
   output logic                coin_reject,
   output logic                chg_valid,
   output logic [1:0]          chg_coin,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   generate
      if ((PRICE_UNITS < 1) || (PRICE_UNITS > (1 << CREDIT_W) - 1)) begin : g_bad_price
         $error("vending_machine_gen2: PRICE_UNITS out of range for CREDIT_W");
      end
   endgenerate

   localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_UNITS);

   vm_state_t           state, state_nx;
   logic [CREDIT_W-1:0] credit_q, credit_nx;
   logic                reject_q, reject_nx;
   logic [1:0]          sel_code;
   logic [2:0]          sel_value;
   logic [2:0]          cval;
   logic [CREDIT_W:0]   sum;
   logic                stock_block;

   vm_change_sel #(.CREDIT_W(CREDIT_W)) u_sel (
      .credit    (credit_q),
      .chg_code  (sel_code),
      .chg_value (sel_value)
   );

`ifdef VM_STOCK_EN
   logic [7:0] stock_q;

   // Restock wins over the decrement at VEND exit.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         stock_q <= STOCK_INIT;
      else if (Restock)
         stock_q <= STOCK_INIT;
      else if (state == ST_VEND && stock_q != 8'd0)
         stock_q <= stock_q - 8'd1;
   end

   assign sold_out    = (stock_q == 8'd0);
   assign stock_block = sold_out && (state == ST_IDLE);
`else
   assign stock_block = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= ST_IDLE;
         credit_q <= '0;
         reject_q <= 1'b0;
      end else begin
         state    <= state_nx;
         credit_q <= credit_nx;
         reject_q <= reject_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      credit_nx = credit_q;
      reject_nx = 1'b0;
      cval      = coin_value(Coin);
      // Top bit of sum set means the credit register would wrap.
      sum       = (CREDIT_W+1)'(credit_q) + (CREDIT_W+1)'(cval);
      case (state)
         ST_IDLE, ST_COLLECT: begin
            if (state == ST_COLLECT && Cancel) begin
               state_nx  = ST_CHANGE;
               reject_nx = (Coin != COIN_NONE);
            end else if (Coin != COIN_NONE) begin
               if (cval != 3'd0 && !sum[CREDIT_W] && !stock_block) begin
                  credit_nx = sum[CREDIT_W-1:0];
                  state_nx  = (credit_nx >= PRICE) ? ST_VEND : ST_COLLECT;
               end else begin
                  reject_nx = 1'b1;
               end
            end
         end
         ST_VEND: begin
            reject_nx = (Coin != COIN_NONE);
            credit_nx = credit_q - PRICE;
            state_nx  = (credit_nx == '0) ? ST_IDLE : ST_CHANGE;
         end
         ST_CHANGE: begin
            reject_nx = (Coin != COIN_NONE);
            if (chg_ready) begin
               credit_nx = credit_q - CREDIT_W'(sel_value);
               if (credit_nx == '0)
                  state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign vending     = (state == ST_VEND);
   assign chg_valid   = (state == ST_CHANGE);
   assign chg_coin    = chg_valid ? sel_code : CHG_NONE;
   assign busy        = vending || chg_valid;
   assign credit      = credit_q;
   assign coin_reject = reject_q;

   always @(posedge Clk) begin
      if (Reset_n) begin
         if (state == ST_VEND)
            assert (credit_q >= PRICE);
         if (state == ST_CHANGE && chg_ready)
            assert (credit_q >= CREDIT_W'(sel_value));
      end
   end

endmodule

// File: tb/tb_vending_machine_gen2.sv
// tb/tb_vending_machine_gen2.sv - self-checking bench for vending_machine_gen2
module tb_vending_machine_gen2;

   localparam int PRICE = 5;
   localparam int MAXC  = 63;
   localparam int SINIT = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, rst2_n;
   logic [2:0] coin, coin2;
   logic       cancel, cancel2, rdy, rdy2;
   logic       vending, coin_reject, chg_valid, busy;
   logic [1:0] chg_coin;
   logic [5:0] credit;
   logic       vending2, coin_reject2, chg_valid2, busy2;
   logic [1:0] chg_coin2;
   logic [2:0] credit2;
`ifdef VM_STOCK_EN
   logic       rs, sold_out, rs2, sold_out2;
   int         m_stock;
`endif

   int total = 0;
   int bad   = 0;

   int m_credit;
   bit m_vend, m_chg, m_rej;

   vending_machine_gen2 #(.PRICE_UNITS(5), .CREDIT_W(6)
`ifdef VM_STOCK_EN
      , .STOCK_INIT(8'(SINIT))
`endif
   ) dut (
      .Clk(clk), .Reset_n(rst_n), .Coin(coin), .Cancel(cancel), .chg_ready(rdy),
`ifdef VM_STOCK_EN
      .Restock(rs), .sold_out(sold_out),
`endif
      .vending(vending), .coin_reject(coin_reject), .chg_valid(chg_valid),
      .chg_coin(chg_coin), .credit(credit), .busy(busy)
   );

   vending_machine_gen2 #(.PRICE_UNITS(7), .CREDIT_W(3)) dut2 (
      .Clk(clk), .Reset_n(rst2_n), .Coin(coin2), .Cancel(cancel2), .chg_ready(rdy2),
`ifdef VM_STOCK_EN
      .Restock(rs2), .sold_out(sold_out2),
`endif
      .vending(vending2), .coin_reject(coin_reject2), .chg_valid(chg_valid2),
      .chg_coin(chg_coin2), .credit(credit2), .busy(busy2)
   );

   function automatic int coinv(input logic [2:0] c);
      case (c)
         3'b001:  return 1;
         3'b010:  return 2;
         3'b101:  return 5;
         default: return 0;
      endcase
   endfunction

   function automatic int greedy(input int c);
      return (c >= 5) ? 5 : (c >= 2) ? 2 : 1;
   endfunction

   function automatic logic [1:0] gcode(input int c);
      return (c >= 5) ? 2'b11 : (c >= 2) ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [11:0] expect_vec();
      return {m_vend, m_rej, m_chg, (m_chg ? gcode(m_credit) : 2'b00), (m_vend | m_chg), 6'(m_credit)};
   endfunction

   task automatic model_reset();
      m_credit = 0; m_vend = 0; m_chg = 0; m_rej = 0;
`ifdef VM_STOCK_EN
      m_stock = SINIT;
`endif
   endtask

   // Behavioural rules applied at one sampling edge.
   task automatic model_step(input logic [2:0] c, input logic cn, input logic r);
      int  old = m_credit;
      int  cv  = coinv(c);
      bit  rej = 0;
      bit  was_vend = m_vend;
      bit  sold = 0;
`ifdef VM_STOCK_EN
      sold = (m_stock == 0);
`endif
      if (m_vend) begin
         m_credit = old - PRICE;
         m_vend   = 0;
         m_chg    = (m_credit > 0);
         rej      = (c != 0);
      end else if (m_chg) begin
         rej = (c != 0);
         if (r) begin
            m_credit = old - greedy(old);
            if (m_credit == 0) m_chg = 0;
         end
      end else if (old > 0 && cn) begin
         m_chg = 1;
         rej   = (c != 0);
      end else if (c != 0) begin
         if (cv > 0 && old + cv <= MAXC && !(sold && old == 0)) begin
            m_credit = old + cv;
            m_vend   = (m_credit >= PRICE);
         end else begin
            rej = 1;
         end
      end
      m_rej = rej;
`ifdef VM_STOCK_EN
      if (rs) m_stock = SINIT;
      else if (was_vend && m_stock > 0) m_stock = m_stock - 1;
`else
      if (was_vend && sold) m_rej = rej;
`endif
   endtask

   task automatic cyc(input logic [2:0] c, input logic cn, input logic r);
      coin = c; cancel = cn; rdy = r;
      @(posedge clk);
      model_step(c, cn, r);
      #1;
   endtask

   task automatic cyc2(input logic [2:0] c);
      coin2 = c;
      @(posedge clk);
      #1;
   endtask

   task automatic refill();
`ifdef VM_STOCK_EN
      rs = 1'b1;
      cyc(3'b000, 1'b0, 1'b0);
      rs = 1'b0;
`endif
   endtask

   task automatic test_reset();
      total++;
      if ({vending, coin_reject, chg_valid, chg_coin, busy, credit} !== 12'd0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=000", {vending, coin_reject, chg_valid, chg_coin, busy, credit});
      end
      total++;
      if ({vending2, coin_reject2, chg_valid2, chg_coin2, busy2, credit2} !== 9'd0) begin
         bad++; $display("FAIL reset_outputs2 got=%h exp=000", {vending2, coin_reject2, chg_valid2, chg_coin2, busy2, credit2});
      end
   endtask

   task automatic test_five_nickels();
      int vend_seen = 0;
      refill();
      for (int i = 1; i <= 5; i++) begin
         cyc(3'b001, 1'b0, 1'b0);
         total++;
         if (credit !== 6'(i)) begin bad++; $display("FAIL nickel_credit got=%0d exp=%0d", credit, i); end
         total++;
         if (vending !== (i == 5)) begin bad++; $display("FAIL nickel_vend got=%0d exp=%0d", vending, (i == 5)); end
         vend_seen += int'(vending); 
      end
      cyc(3'b000, 1'b0, 1'b1);
      vend_seen += int'(vending);
      total++;
      if (vend_seen != 1) begin bad++; $display("FAIL nickel_vend_count got=%0d exp=1", vend_seen); end
      total++;
      if ({credit, chg_valid, busy} !== 8'd0) begin bad++; $display("FAIL nickel_after got=%h exp=00", {credit, chg_valid, busy}); end
   endtask

   task automatic test_change_hold();
      refill();
      cyc(3'b001, 1'b0, 1'b0);
      cyc(3'b101, 1'b0, 1'b0);
      total++;
      if ({vending, credit} !== {1'b1, 6'd6}) begin bad++; $display("FAIL hold_vend got=%h exp=%h", {vending, credit}, {1'b1, 6'd6}); end
      for (int i = 0; i < 4; i++) begin
         cyc(3'b000, 1'b0, 1'b0);
         total++;
         if ({chg_valid, chg_coin, credit} !== {1'b1, 2'b01, 6'd1}) begin
            bad++; $display("FAIL hold_chg_%0d got=%h exp=%h", i, {chg_valid, chg_coin, credit}, {1'b1, 2'b01, 6'd1});
         end
      end
      cyc(3'b000, 1'b0, 1'b1);
      total++;
      if ({chg_valid, busy, credit} !== 8'd0) begin bad++; $display("FAIL hold_done got=%h exp=00", {chg_valid, busy, credit}); end
   endtask

   task automatic test_back_to_back();
      refill();
      cyc(3'b010, 1'b0, 1'b1);
      cyc(3'b010, 1'b0, 1'b1);
      cyc(3'b101, 1'b0, 1'b1);
      total++;
      if ({vending, credit} !== {1'b1, 6'd9}) begin bad++; $display("FAIL b2b_vend got=%h exp=%h", {vending, credit}, {1'b1, 6'd9}); end
      cyc(3'b000, 1'b0, 1'b1);
      total++;
      if ({chg_valid, chg_coin, credit} !== {1'b1, 2'b10, 6'd4}) begin bad++; $display("FAIL b2b_first got=%h exp=%h", {chg_valid, chg_coin, credit}, {1'b1, 2'b10, 6'd4}); end
      cyc(3'b000, 1'b0, 1'b1);
      total++;
      if ({chg_valid, chg_coin, credit} !== {1'b1, 2'b10, 6'd2}) begin bad++; $display("FAIL b2b_second got=%h exp=%h", {chg_valid, chg_coin, credit}, {1'b1, 2'b10, 6'd2}); end
      cyc(3'b000, 1'b0, 1'b1);
      total++;
      if ({chg_valid, busy, credit} !== 8'd0) begin bad++; $display("FAIL b2b_idle got=%h exp=00", {chg_valid, busy, credit}); end
   endtask

   task automatic test_cancel();
      refill();
      cyc(3'b010, 1'b0, 1'b0);
      cyc(3'b001, 1'b1, 1'b0);
      total++;
      if ({coin_reject, vending, chg_valid, chg_coin, credit} !== {1'b1, 1'b0, 1'b1, 2'b10, 6'd2}) begin
         bad++; $display("FAIL cancel_change got=%h exp=%h", {coin_reject, vending, chg_valid, chg_coin, credit}, {1'b1, 1'b0, 1'b1, 2'b10, 6'd2});
      end
      cyc(3'b000, 1'b0, 1'b1);
      total++;
      if ({coin_reject, chg_valid, credit} !== 8'd0) begin bad++; $display("FAIL cancel_done got=%h exp=00", {coin_reject, chg_valid, credit}); end
      cyc(3'b011, 1'b0, 1'b0);
      total++;
      if ({coin_reject, credit} !== {1'b1, 6'd0}) begin bad++; $display("FAIL invalid_code got=%h exp=%h", {coin_reject, credit}, {1'b1, 6'd0}); end
      cyc(3'b001, 1'b0, 1'b0);
      cyc(3'b000, 1'b1, 1'b0);
      cyc(3'b101, 1'b0, 1'b0);
      total++;
      if ({coin_reject, chg_valid, credit} !== {1'b1, 1'b1, 6'd1}) begin bad++; $display("FAIL reject_in_change got=%h exp=%h", {coin_reject, chg_valid, credit}, {1'b1, 1'b1, 6'd1}); end
      cyc(3'b000, 1'b0, 1'b1);
      total++;
      if ({coin_reject, chg_valid, credit} !== 8'd0) begin bad++; $display("FAIL reject_done got=%h exp=00", {coin_reject, chg_valid, credit}); end
   endtask

   task automatic test_saturation();
      cyc2(3'b101);
      total++;
      if ({coin_reject2, credit2} !== {1'b0, 3'd5}) begin bad++; $display("FAIL sat_first got=%h exp=%h", {coin_reject2, credit2}, {1'b0, 3'd5}); end
      cyc2(3'b101);
      total++;
      if ({coin_reject2, credit2} !== {1'b1, 3'd5}) begin bad++; $display("FAIL sat_quarter got=%h exp=%h", {coin_reject2, credit2}, {1'b1, 3'd5}); end
      cyc2(3'b001);
      cyc2(3'b010);
      total++;
      if ({coin_reject2, credit2} !== {1'b1, 3'd6}) begin bad++; $display("FAIL sat_dime got=%h exp=%h", {coin_reject2, credit2}, {1'b1, 3'd6}); end
      cyc2(3'b001);
      total++;
      if ({vending2, credit2} !== {1'b1, 3'd7}) begin bad++; $display("FAIL sat_vend got=%h exp=%h", {vending2, credit2}, {1'b1, 3'd7}); end
      cyc2(3'b000);
      total++;
      if ({vending2, busy2, credit2} !== 5'd0) begin bad++; $display("FAIL sat_idle got=%h exp=00", {vending2, busy2, credit2}); end
   endtask

   task automatic test_reset_mid_change();
      refill();
      cyc(3'b001, 1'b0, 1'b0);
      cyc(3'b101, 1'b0, 1'b0);
      cyc(3'b000, 1'b0, 1'b0);
      total++;
      if (chg_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%0d exp=1", chg_valid); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({vending, coin_reject, chg_valid, chg_coin, busy, credit} !== 12'd0) begin
         bad++; $display("FAIL midrst_outputs got=%h exp=000", {vending, coin_reject, chg_valid, chg_coin, busy, credit});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      cyc(3'b000, 1'b0, 1'b1);
      total++;
      if ({chg_valid, busy, credit} !== 8'd0) begin bad++; $display("FAIL midrst_idle got=%h exp=00", {chg_valid, busy, credit}); end
   endtask

   task automatic test_random();
      logic [2:0] codes [7] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b101, 3'b011, 3'b111};
      logic [11:0] exp_v;
      refill();
      for (int i = 0; i < 400; i++) begin
`ifdef VM_STOCK_EN
         rs = ($urandom_range(0, 7) == 0);
`endif
         cyc(codes[$urandom_range(0, 6)], ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
         exp_v = expect_vec();
         total++;
         if ({vending, coin_reject, chg_valid, chg_coin, busy, credit} !== exp_v) begin
            bad++; $display("FAIL random_%0d got=%h exp=%h", i, {vending, coin_reject, chg_valid, chg_coin, busy, credit}, exp_v);
         end
`ifdef VM_STOCK_EN
         total++;
         if (sold_out !== (m_stock == 0)) begin bad++; $display("FAIL random_sold_%0d got=%0d exp=%0d", i, sold_out, (m_stock == 0)); end
`endif
      end
`ifdef VM_STOCK_EN
      rs = 1'b0;
`endif
      for (int i = 0; i < 20; i++) begin
         if (m_credit > 0 && !m_chg && !m_vend) cyc(3'b000, 1'b1, 1'b1);
         else if (m_credit > 0) cyc(3'b000, 1'b0, 1'b1);
      end
      total++;
      if ({busy, credit} !== 7'd0) begin bad++; $display("FAIL random_drain got=%h exp=00", {busy, credit}); end
   endtask

`ifdef VM_STOCK_EN
   task automatic test_stock();
      refill();
      for (int i = 0; i < 5; i++) cyc(3'b001, 1'b0, 1'b0);
      cyc(3'b000, 1'b0, 1'b0);
      total++;
      if (sold_out !== 1'b1) begin bad++; $display("FAIL stock_sold got=%0d exp=1", sold_out); end
      cyc(3'b001, 1'b0, 1'b0);
      total++;
      if ({coin_reject, credit} !== {1'b1, 6'd0}) begin bad++; $display("FAIL stock_reject got=%h exp=%h", {coin_reject, credit}, {1'b1, 6'd0}); end
      refill();
      total++;
      if (sold_out !== 1'b0) begin bad++; $display("FAIL stock_restock got=%0d exp=0", sold_out); end
      cyc(3'b001, 1'b0, 1'b0);
      total++;
      if ({coin_reject, credit} !== {1'b0, 6'd1}) begin bad++; $display("FAIL stock_accept got=%h exp=%h", {coin_reject, credit}, {1'b0, 6'd1}); end
      cyc(3'b000, 1'b1, 1'b1);
      cyc(3'b000, 1'b0, 1'b1);
   endtask
`endif

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      coin = '0; coin2 = '0; cancel = 1'b0; cancel2 = 1'b0; rdy = 1'b0; rdy2 = 1'b0;
`ifdef VM_STOCK_EN
      rs = 1'b0; rs2 = 1'b0;
`endif
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1; rst2_n = 1'b1;
      test_five_nickels();
      test_change_hold();
      test_back_to_back();
      test_cancel();
      test_saturation();
      test_reset_mid_change();
      test_random();
`ifdef VM_STOCK_EN
      test_stock();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
